// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus controller.
//   NMI_VECTOR        opcode-fetch address that retires a pending NMI
//   INTACK_IDLE_DATA  byte returned during int-ack when no vector is supplied
//   MAX_IRQ           widest supported interrupt controller
//   wait_state_t      wait FSM state encoding (IDLE, HOLD)
//   prio_enc()        lowest-index-wins priority encoder with valid flag
package z80_bus_pkg;

  localparam logic [15:0] NMI_VECTOR       = 16'h0066;
  localparam logic [7:0]  INTACK_IDLE_DATA = 8'hFF;
  localparam int          MAX_IRQ          = 8;

  typedef logic [0:0] wait_state_t;
  localparam wait_state_t IDLE = 1'b0;
  localparam wait_state_t HOLD = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  // Scan from the top down so the lowest set index is the one left in r.
  function automatic prio_t prio_enc(input logic [MAX_IRQ-1:0] pending);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Wait-state generator.
//   clk, reset_n  clock, asynchronous active-low reset
//   start         one-clock access-start strobe
//   n             number of wait clocks for this access (0 = none)
//   wait_n        active-low WAIT to the CPU
// On start with n>0 WAIT drops in the same clock, then stays low for n-1
// further clocks while the counter drains.
module z80_wait_gen
  import z80_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] n,
  output logic       wait_n
);

  wait_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_n  = 1'b1;
    case (state_q)
      IDLE: begin
        if (start && (n != 4'd0)) begin
          wait_n  = 1'b0;
          cnt_d   = n - 4'd1;
          state_d = HOLD;
        end
      end
      default: begin
        if (cnt_q != 4'd0) begin
          wait_n = 1'b0;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Bus controller between a T80-class core and the system.
//   cpu_* side : raw active-low Z80 bus in, cpu_di/cpu_wait_n/cpu_int_n/cpu_nmi_n out
//   system side: adr/data_out/data_in, level strobes rd/wr/ir/iw,
//                write pulses wr_pulse/iw_pulse
//   interrupts : irq_req (rising-edge), irq_ack (one-clock pulse), nmi_req (rising-edge)
// Build option: define Z80_BUS_IM2_VECTOR_EN to return VECTOR_BASE | (sel<<1)
// during interrupt acknowledge; otherwise 8'hFF is returned (RST 38h).
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter int          MEM_WAIT    = 0,
  parameter int          IO_WAIT     = 1,
  parameter logic [7:0]  VECTOR_BASE = 8'hE0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        cpu_a,
  input  logic [7:0]         cpu_do,
  output logic [7:0]         cpu_di,
  input  logic               cpu_mreq_n,
  input  logic               cpu_iorq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  input  logic               cpu_rfsh_n,
  input  logic               cpu_m1_n,
  output logic               cpu_wait_n,
  output logic               cpu_int_n,
  output logic               cpu_nmi_n,
  output logic [15:0]        adr,
  output logic [7:0]         data_out,
  input  logic [7:0]         data_in,
  output logic               rd,
  output logic               wr,
  output logic               ir,
  output logic               iw,
  output logic               wr_pulse,
  output logic               iw_pulse,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               nmi_req
);

`ifdef Z80_BUS_IM2_VECTOR_EN
  localparam bit IM2_EN = 1'b1;
`else
  localparam bit IM2_EN = 1'b0;
`endif

  localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N  = 4'(IO_WAIT);

  logic mreq, iorq, int_ack, nmi_clr;
  logic mem_acc, io_acc, mem_start, io_start, acc_start, ack_first, ack_end;
  logic mem_prev_q, mem_prev_d, io_prev_q, io_prev_d;
  logic wr_prev_q, wr_prev_d, iw_prev_q, iw_prev_d;
  logic ack_prev_q, ack_prev_d;
  logic nmi_prev_q, nmi_prev_d, nmi_pend_q, nmi_pend_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d, pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d, irq_edge;
  logic [2:0]         sel_q, sel_d;
  logic               sel_vld_q, sel_vld_d;
  logic [MAX_IRQ-1:0] pend_ext, clr_full;
  prio_t              enc;
  logic [2:0]         cur_idx;
  logic               cur_vld;
  logic [3:0]         wait_n_sel;

  // Refresh cycles assert MREQ but are not system accesses; an int-ack
  // asserts IORQ with M1 and must not look like an IO access.
  assign mreq    = ~cpu_mreq_n & cpu_rfsh_n;
  assign iorq    = ~cpu_iorq_n & cpu_m1_n;
  assign int_ack = ~cpu_m1_n & ~cpu_iorq_n;

  assign rd = mreq & ~cpu_rd_n;
  assign wr = mreq & ~cpu_wr_n;
  assign ir = iorq & ~cpu_rd_n;
  assign iw = iorq & ~cpu_wr_n;

  assign adr      = cpu_a;
  assign data_out = cpu_do;

  // Edge detectors are held off while reset is low so that an access still
  // on the bus during reset cannot drop WAIT or fire a pulse.
  assign wr_pulse  = wr & ~wr_prev_q & reset_n;
  assign iw_pulse  = iw & ~iw_prev_q & reset_n;
  assign mem_acc   = rd | wr;
  assign io_acc    = ir | iw;
  assign mem_start = mem_acc & ~mem_prev_q;
  assign io_start  = io_acc & ~io_prev_q;
  assign acc_start = (mem_start | io_start) & reset_n;
  assign wait_n_sel = mem_start ? MEM_N : IO_N;

  z80_wait_gen u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (acc_start),
    .n       (wait_n_sel),
    .wait_n  (cpu_wait_n)
  );

  assign ack_first = int_ack & ~ack_prev_q;
  assign ack_end   = ~int_ack & ack_prev_q;
  assign irq_edge  = irq_req & ~irq_prev_q;
  assign nmi_clr   = ~cpu_m1_n & ~cpu_mreq_n & (cpu_a == NMI_VECTOR);

  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_IRQ-1:0] = pending_q;
  end

  assign enc = prio_enc(pend_ext);
  // The first ack clock uses the live encoder; later clocks use the captured
  // selection so a new request mid-ack cannot change the vector.
  assign cur_idx = ack_first ? enc.idx   : sel_q;
  assign cur_vld = ack_first ? enc.valid : sel_vld_q;

  always_comb begin
    cpu_di = data_in;
    if (int_ack) begin
      cpu_di = (IM2_EN && cur_vld) ? (VECTOR_BASE | {4'b0000, cur_idx, 1'b0})
                                   : INTACK_IDLE_DATA;
    end
  end

  always_comb begin
    mem_prev_d = mem_acc;
    io_prev_d  = io_acc;
    wr_prev_d  = wr;
    iw_prev_d  = iw;
    ack_prev_d = int_ack;
    irq_prev_d = irq_req;
    nmi_prev_d = nmi_req;
    sel_d      = sel_q;
    sel_vld_d  = sel_vld_q;
    if (ack_first) begin
      sel_d     = enc.idx;
      sel_vld_d = enc.valid;
    end
    clr_full = '0;
    if (ack_end && sel_vld_q) clr_full[sel_q] = 1'b1;
    irq_ack_d  = clr_full[NUM_IRQ-1:0];
    // Set after clear: a fresh edge on the channel being retired survives.
    pending_d  = (pending_q & ~clr_full[NUM_IRQ-1:0]) | irq_edge;
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi_req & ~nmi_prev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_prev_q <= 1'b0;
      io_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      iw_prev_q  <= 1'b0;
      ack_prev_q <= 1'b0;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      sel_q      <= 3'd0;
      sel_vld_q  <= 1'b0;
      irq_ack_q  <= '0;
      pending_q  <= '0;
      nmi_pend_q <= 1'b0;
    end else begin
      mem_prev_q <= mem_prev_d;
      io_prev_q  <= io_prev_d;
      wr_prev_q  <= wr_prev_d;
      iw_prev_q  <= iw_prev_d;
      ack_prev_q <= ack_prev_d;
      irq_prev_q <= irq_prev_d;
      nmi_prev_q <= nmi_prev_d;
      sel_q      <= sel_d;
      sel_vld_q  <= sel_vld_d;
      irq_ack_q  <= irq_ack_d;
      pending_q  <= pending_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign irq_ack   = irq_ack_q;
  assign cpu_int_n = ~|pending_q;
  assign cpu_nmi_n = ~nmi_pend_q;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
module tb_z80_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do, cpu_di, data_out, data_in;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_m1_n;
  logic        cpu_wait_n, cpu_int_n, cpu_nmi_n;
  logic [15:0] adr;
  logic        rd, wr, ir, iw, wr_pulse, iw_pulse;
  logic [3:0]  irq_req, irq_ack;
  logic        nmi_req;

  int checks = 0;
  int errors = 0;

`ifdef Z80_BUS_IM2_VECTOR_EN
  localparam logic [7:0] VEC_CH0 = 8'hE0;
  localparam logic [7:0] VEC_CH1 = 8'hE2;
  localparam logic [7:0] VEC_CH3 = 8'hE6;
`else
  localparam logic [7:0] VEC_CH0 = 8'hFF;
  localparam logic [7:0] VEC_CH1 = 8'hFF;
  localparam logic [7:0] VEC_CH3 = 8'hFF;
`endif

  always #5 clk = ~clk;

  z80_bus_ctrl #(
    .NUM_IRQ(4), .MEM_WAIT(5), .IO_WAIT(3), .VECTOR_BASE(8'hE0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_m1_n(cpu_m1_n),
    .cpu_wait_n(cpu_wait_n), .cpu_int_n(cpu_int_n), .cpu_nmi_n(cpu_nmi_n),
    .adr(adr), .data_out(data_out), .data_in(data_in),
    .rd(rd), .wr(wr), .ir(ir), .iw(iw), .wr_pulse(wr_pulse), .iw_pulse(iw_pulse),
    .irq_req(irq_req), .irq_ack(irq_ack), .nmi_req(nmi_req)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks sit on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1; cpu_rfsh_n = 1'b1; cpu_m1_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_a = 16'h0000; cpu_do = 8'h00; data_in = 8'h00;
    irq_req = 4'b0000; nmi_req = 1'b0;
    bus_idle();
    tick(); tick();
    @(negedge clk);
    chk("rst_wait_n", 16'(cpu_wait_n), 16'h1);
    chk("rst_int_n", 16'(cpu_int_n), 16'h1);
    chk("rst_nmi_n", 16'(cpu_nmi_n), 16'h1);
    chk("rst_irq_ack", 16'(irq_ack), 16'h0);
    chk("rst_wr_pulse", 16'(wr_pulse), 16'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Refresh cycle: no rd, no wait; then a real read starts a 5-clock wait.
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_a = 16'h1234;
    @(negedge clk);
    chk("rfsh_rd", 16'(rd), 16'h0);
    chk("rfsh_wait", 16'(cpu_wait_n), 16'h1);
    chk("adr_pass", adr, 16'h1234);
    tick();
    @(negedge clk);
    chk("rfsh_wait2", 16'(cpu_wait_n), 16'h1);
    tick();
    cpu_rfsh_n = 1'b1;
    @(negedge clk);
    chk("mem_rd", 16'(rd), 16'h1);
    chk("mem_wait_start", 16'(cpu_wait_n), 16'h0);
    for (int i = 1; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("mem_wait_cnt", 16'(cpu_wait_n), (i < 5) ? 16'h0 : 16'h1);
    end
    tick();
    bus_idle();
    tick();

    // IO write, IO_WAIT=3, held 6 clocks.
    cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; cpu_do = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("io_iw", 16'(iw), 16'h1);
      chk("io_iw_pulse", 16'(iw_pulse), (i == 0) ? 16'h1 : 16'h0);
      chk("io_wait", 16'(cpu_wait_n), (i < 3) ? 16'h0 : 16'h1);
      tick();
    end
    chk("io_data_out", 16'(data_out), 16'h00A5);
    bus_idle();
    tick();

    // Memory write pulse (wait also runs; just the pulse is checked here).
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clk);
    chk("mem_wr_pulse0", 16'(wr_pulse), 16'h1);
    tick();
    @(negedge clk);
    chk("mem_wr_pulse1", 16'(wr_pulse), 16'h0);
    chk("mem_wr_level", 16'(wr), 16'h1);
    tick();
    bus_idle();
    for (int i = 0; i < 6; i++) tick();

    // Two interrupt edges together; channel 1 served first, then channel 3.
    data_in = 8'h5A;
    irq_req = 4'b1010;
    tick();
    irq_req = 4'b0000;
    @(negedge clk);
    chk("irq_int_n", 16'(cpu_int_n), 16'h0);
    chk("di_normal", 16'(cpu_di), 16'h005A);
    tick();
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    @(negedge clk);
    chk("ack1_vec", 16'(cpu_di), 16'(VEC_CH1));
    chk("ack_no_ir", 16'({ir, iw}), 16'h0);
    tick();
    @(negedge clk);
    chk("ack1_vec_hold", 16'(cpu_di), 16'(VEC_CH1));
    tick();
    bus_idle();
    @(negedge clk);
    chk("ack1_no_early", 16'(irq_ack), 16'h0);
    tick();
    @(negedge clk);
    chk("ack1_irq_ack", 16'(irq_ack), 16'b0010);
    chk("ack1_int_n", 16'(cpu_int_n), 16'h0);
    tick();
    @(negedge clk);
    chk("ack1_pulse_end", 16'(irq_ack), 16'h0);
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    @(negedge clk);
    chk("ack3_vec", 16'(cpu_di), 16'(VEC_CH3));
    tick();
    bus_idle();
    tick();
    @(negedge clk);
    chk("ack3_irq_ack", 16'(irq_ack), 16'b1000);
    chk("ack3_int_n", 16'(cpu_int_n), 16'h1);
    tick();

    // Ack with nothing pending: 8'hFF, no acknowledge pulse.
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    @(negedge clk);
    chk("ack_none_di", 16'(cpu_di), 16'h00FF);
    tick();
    bus_idle();
    tick();
    @(negedge clk);
    chk("ack_none_irq_ack", 16'(irq_ack), 16'h0);
    tick();

    // New edge on channel 0 in the ack-end clock of channel 0: set wins.
    irq_req = 4'b0001;
    tick();
    irq_req = 4'b0000;
    tick();
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    @(negedge clk);
    chk("ack0_vec", 16'(cpu_di), 16'(VEC_CH0));
    tick();
    bus_idle();
    irq_req = 4'b0001;
    tick();
    irq_req = 4'b0000;
    @(negedge clk);
    chk("race_irq_ack", 16'(irq_ack), 16'b0001);
    chk("race_int_n", 16'(cpu_int_n), 16'h0);
    tick();
    cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0;
    tick();
    bus_idle();
    tick();
    @(negedge clk);
    chk("race_clear_ack", 16'(irq_ack), 16'b0001);
    chk("race_clear_int_n", 16'(cpu_int_n), 16'h1);
    tick();

    // NMI: only a fetch at 0066h retires it.
    nmi_req = 1'b1;
    tick();
    @(negedge clk);
    chk("nmi_set", 16'(cpu_nmi_n), 16'h0);
    tick();
    cpu_m1_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_a = 16'h0065;
    tick();
    @(negedge clk);
    chk("nmi_0065", 16'(cpu_nmi_n), 16'h0);
    tick();
    cpu_a = 16'h0066;
    @(negedge clk);
    chk("nmi_0066_same", 16'(cpu_nmi_n), 16'h0);
    tick();
    bus_idle();
    nmi_req = 1'b0;
    @(negedge clk);
    chk("nmi_cleared", 16'(cpu_nmi_n), 16'h1);
    for (int i = 0; i < 6; i++) tick();

    // Async reset during a memory wait with channel 0 pending.
    irq_req = 4'b0001;
    tick();
    irq_req = 4'b0000;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_wait", 16'(cpu_wait_n), 16'h0);
    chk("pre_rst_int", 16'(cpu_int_n), 16'h0);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_wait", 16'(cpu_wait_n), 16'h1);
    chk("async_rst_int", 16'(cpu_int_n), 16'h1);
    tick();
    bus_idle();
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_wait", 16'(cpu_wait_n), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
